// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// datapath width and small helpers used by the top and the divider step.
package muldiv_unit_pkg;

  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 1;

  // One-hot operation encodings as produced by the R-type decoder.
  localparam logic [3:0] MULT_MC  = 4'b0001;
  localparam logic [3:0] MULTU_MC = 4'b0010;
  localparam logic [3:0] DIV_MC   = 4'b0100;
  localparam logic [3:0] DIVU_MC  = 4'b1000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Two's-complement magnitude when en is set; raw value otherwise.
  function automatic logic [XLEN-1:0] abs_xlen(input logic [XLEN-1:0] v, input logic en);
    return (en && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the result if it did not borrow.
module div_iter
  import muldiv_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            borrow;

  // When the trial succeeds the true difference is below the divisor, so the
  // low XLEN bits of the subtraction carry the whole result.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    borrow  = shifted < {1'b0, divisor};
    diff    = shifted[XLEN-1:0] - divisor;
    rem_nxt = borrow ? shifted[XLEN-1:0] : diff;
    quo_nxt = {quo[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 2-cycle multiply, 33-cycle restoring divide,
// mthi/mtlo writes in idle, flush via cancel.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      mul_control,
  input  logic            mul_valid,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            cancel,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t              state, state_nxt;
  logic                start, div_op, signed_op, div_signed;
  logic [MUL_STAGES:0] vld_pipe;
  logic [XLEN-1:0]     op_a_q, op_b_q, quo_q, rem_q;
  logic [XLEN-1:0]     quo_nxt, rem_nxt, quo_fix, rem_fix;
  logic [2*XLEN-1:0]   ext_a, ext_b, prod_q;
  logic                signed_q, sign_a_q, sign_b_q, div_zero_q;
  logic [4:0]          cnt;
  logic                mul_done, fix_done, idle_wr;

  assign div_op     = mul_control[2] | mul_control[3];
  assign signed_op  = mul_control[0] | mul_control[2];
  assign div_signed = div_op & signed_op;
  assign start      = (state == S_IDLE) && mul_valid && !cancel && is_onehot4(mul_control);
  assign busy       = (state != S_IDLE);

  assign ext_a = {{XLEN{signed_q & op_a_q[XLEN-1]}}, op_a_q};
  assign ext_b = {{XLEN{signed_q & op_b_q[XLEN-1]}}, op_b_q};

  // Divisor magnitude sits in op_b_q; the dividend magnitude is shifted out of quo_q.
  div_iter u_div_iter (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (op_b_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign quo_fix = (sign_a_q ^ sign_b_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = sign_a_q ? (~rem_q + 1'b1) : rem_q;

  assign mul_done = (state == S_MUL) && vld_pipe[MUL_STAGES] && !cancel;
  assign fix_done = (state == S_FIX) && !cancel && !div_zero_q;
  assign idle_wr  = (state == S_IDLE) && !start;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = div_op ? S_DIV : S_MUL;
      S_MUL:  if (cancel || vld_pipe[MUL_STAGES]) state_nxt = S_IDLE;
      S_DIV:  if (cancel) state_nxt = S_IDLE;
              else if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      vld_pipe   <= '0;
      cnt        <= 5'd0;
      hi         <= '0;
      lo         <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      prod_q     <= '0;
      signed_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= cancel ? '0 : {vld_pipe[MUL_STAGES-1:0], start & ~div_op};

      if (start) begin
        op_a_q     <= op_a;
        op_b_q     <= abs_xlen(op_b, div_signed);
        quo_q      <= abs_xlen(op_a, div_signed);
        rem_q      <= '0;
        cnt        <= 5'd0;
        signed_q   <= signed_op;
        sign_a_q   <= div_signed & op_a[XLEN-1];
        sign_b_q   <= div_signed & op_b[XLEN-1];
        div_zero_q <= (op_b == '0);
      end

      if (state == S_DIV) begin
        quo_q <= quo_nxt;
        rem_q <= rem_nxt;
        cnt   <= cnt + 5'd1;
      end

      if (vld_pipe[0]) prod_q <= ext_a * ext_b;

      if (mul_done) begin
        hi <= prod_q[2*XLEN-1:XLEN];
        lo <= prod_q[XLEN-1:0];
      end else if (fix_done) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else if (idle_wr) begin
        // cancel only blocks starts, so mthi/mtlo still land here
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic HI/LO model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mul_control;
  logic        mul_valid;
  logic [31:0] op_a, op_b;
  logic        cancel;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit dut (
    .clk         (clk),
    .rst         (rst),
    .mul_control (mul_control),
    .mul_valid   (mul_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .cancel      (cancel),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Reference: architectural HI/LO effect of one completed operation.
  task automatic model_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    case (c)
      4'b0001: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      4'b0010: begin
        up = {32'h0, a} * {32'h0, b};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      4'b0100: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sp = sa / sb; m_lo = sp[31:0];
        sp = sa % sb; m_hi = sp[31:0];
      end
      4'b1000: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input string name);
    int cyc, exp_cyc;
    @(negedge clk);
    mul_control = c; op_a = a; op_b = b; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    wait_idle(cyc);
    model_op(c, a, b);
    exp_cyc = (c[0] | c[1]) ? 2 : 33;
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d exp %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL %s result a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", name, a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic idle_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    hi_we = h; lo_we = l; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; mul_valid = 1'b1; mul_control = 4'b0100; hi_we = 1'b1; lo_we = 1'b1;
    wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    mul_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
    end
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
  endtask

  task automatic test_mul();
    run_op(4'b0001, 32'hFFFF_FFFF, 32'h2, "mult_neg1x2");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mult_const got %h_%h exp ffffffff_fffffffe", hi, lo);
    end
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h2, "multu_max_x2");
    checks++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu_const got %h_%h exp 00000001_fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    run_op(4'b0100, 32'hFFFF_FFF9, 32'h2, "div_neg7_2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_const got hi=%h lo=%h exp ffffffff/fffffffd", hi, lo);
    end
    run_op(4'b1000, 32'hFFFF_FFF9, 32'h2, "divu_big_2");
    checks++;
    if (lo !== 32'h7FFF_FFFC || hi !== 32'h1) begin
      errors++; $display("FAIL divu_const got hi=%h lo=%h exp 00000001/7ffffffc", hi, lo);
    end
  endtask

  task automatic test_div_special();
    run_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow_const got hi=%h lo=%h exp 0/80000000", hi, lo);
    end
    idle_write(1'b1, 1'b1, 32'h0000_ABCD);
    run_op(4'b1000, 32'h5, 32'h0, "divu_by_zero");
    checks++;
    if (hi !== 32'h0000_ABCD || lo !== 32'h0000_ABCD) begin
      errors++; $display("FAIL div_zero_keep got hi=%h lo=%h exp 0000abcd", hi, lo);
    end
    run_op(4'b0100, 32'h8000_0000, 32'h0, "div_by_zero_signed");
  endtask

  task automatic test_cancel();
    // div cancelled at E10
    @(negedge clk);
    mul_control = 4'b0100; op_a = 32'd1000; op_b = 32'd7; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL cancel_div got busy=%b hi=%h lo=%h exp 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
    idle_write(1'b1, 1'b0, 32'h0000_1234);
    checks++;
    if (hi !== 32'h0000_1234 || lo !== m_lo) begin
      errors++; $display("FAIL mthi_after_cancel got hi=%h lo=%h exp 00001234 %h", hi, lo, m_lo);
    end
    // mult cancelled on its completing edge
    @(negedge clk);
    mul_control = 4'b0010; op_a = 32'd9; op_b = 32'd9; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL cancel_mul_e2 got busy=%b hi=%h lo=%h exp 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
    // div cancelled on its completing edge (FIX)
    @(negedge clk);
    mul_control = 4'b1000; op_a = 32'd77; op_b = 32'd5; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (32) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL cancel_div_e33 got busy=%b hi=%h lo=%h exp 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_idle_rules();
    int cyc;
    // non-one-hot control is ignored
    @(negedge clk);
    mul_control = 4'b0011; op_a = 32'd3; op_b = 32'd4; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL bad_control got busy=%b hi=%h lo=%h", busy, hi, lo);
    end
    // start beats same-cycle mthi/mtlo
    @(negedge clk);
    mul_control = 4'b0010; op_a = 32'd7; op_b = 32'd6; mul_valid = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_5555;
    @(negedge clk);
    mul_valid = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_idle(cyc);
    model_op(4'b0010, 32'd7, 32'd6);
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL start_beats_write got hi=%h lo=%h exp %h %h", hi, lo, m_hi, m_lo);
    end
    // cancel in idle blocks start but not writes
    @(negedge clk);
    mul_control = 4'b0001; mul_valid = 1'b1; cancel = 1'b1; hi_we = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    mul_valid = 1'b0; cancel = 1'b0; hi_we = 1'b0;
    m_hi = 32'hCAFE_0001;
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL idle_cancel got busy=%b hi=%h lo=%h exp 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    mul_control = 4'b0100; op_a = 32'd100; op_b = 32'hFFFF_FFF9; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (4) @(negedge clk);
    mul_control = 4'b0010; op_a = 32'd3; op_b = 32'd3; mul_valid = 1'b1;
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    mul_valid = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    wait_idle(cyc);
    cyc += 5;
    model_op(4'b0100, 32'd100, 32'hFFFF_FFF9);
    checks++;
    if (cyc !== 33) begin
      errors++; $display("FAIL busy_ignore cycles got %0d exp 33", cyc);
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL busy_ignore result got hi=%h lo=%h exp %h %h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    mul_control = 4'b1000; op_a = 32'd12345; op_b = 32'd10; mul_valid = 1'b1;
    @(negedge clk);
    mul_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL rst_mid got busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
          errors++; $display("FAIL rand_write got hi=%h lo=%h exp %h %h", hi, lo, m_hi, m_lo);
        end
      end else begin
        c = 4'b0001 << $urandom_range(0, 3);
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'h0;
          1: b = 32'hFFFF_FFFF;
          2: b = 32'($urandom_range(1, 15));
          3: a = 32'h8000_0000;
          default: ;
        endcase
        run_op(c, a, b, "random");
      end
    end
  endtask

  initial begin
    rst = 1'b1; mul_control = 4'b0; mul_valid = 1'b0; op_a = 32'h0; op_b = 32'h0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_cancel();
    test_idle_rules();
    test_busy_ignore();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all datapaths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mul_control  input  4  operation select from the R-type decoder, one-hot: mult=0001, multu=0010, div=0100, divu=1000.
REQ-005 mul_valid  input  1  start request; qualifies mul_control, op_a, op_b.
REQ-006 op_a  input  32  rs value: multiplicand or dividend.
REQ-007 op_b  input  32  rt value: multiplier or divisor.
REQ-008 cancel  input  1  aborts the in-flight operation (pipeline flush).
REQ-009 hi_we  input  1  mthi write strobe.
REQ-010 lo_we  input  1  mtlo write strobe.
REQ-011 wdata  input  32  mthi/mtlo data.
REQ-012 busy  output  1  operation in flight; upstream stalls any muldiv, mthi/mtlo, mfhi or mflo while high.
REQ-013 hi  output  32  HI register, driven directly from the flop.
REQ-014 lo  output  32  LO register, driven directly from the flop.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and FIX; busy = (state != IDLE).
REQ-016 In IDLE, mul_valid with exactly one mul_control bit set SHALL start an operation at that edge (E0); any other mul_control value SHALL be ignored.
REQ-017 Mult/multu: IDLE->MUL at E0 with the operands latched; the signed or unsigned 64-bit product registered at E1; HI=product[63:32] and LO=product[31:0] written at E2, together with MUL->IDLE.
REQ-018 Div/divu: at E0 latch the magnitudes (two's-complement absolute value for div, raw value for divu) and both sign bits, IDLE->DIV.
REQ-019 DIV SHALL run exactly 32 restoring iterations, one per edge, E1..E32, counted by a 5-bit counter; DIV->FIX at E32.
REQ-020 FIX at E33: for div, negate the quotient if the sign bits differ and give the remainder the sign of the dividend; LO=quotient, HI=remainder; FIX->IDLE. busy is high for exactly 33 cycles.
REQ-021 For 0x80000000 div 0xFFFFFFFF the result SHALL be LO=0x80000000, HI=0 (wrap, no exception).
REQ-022 Divide by zero SHALL take the full 33 cycles and leave HI and LO unchanged.
REQ-023 In IDLE, hi_we/lo_we SHALL write wdata to HI/LO at the next edge; both may be asserted together.
REQ-024 hi_we/lo_we while busy, and mul_valid while busy, SHALL be ignored.
REQ-025 When mul_valid starts an operation in the same cycle as hi_we or lo_we, mul_valid wins and the writes are ignored.
REQ-026 cancel in any non-IDLE state SHALL return the FSM to IDLE at the next edge with HI/LO unchanged. This includes the completing edge E2/E33, where cancel suppresses the write.
REQ-027 cancel in IDLE SHALL block a same-cycle start, but SHALL NOT block mthi/mtlo writes.

Reset
REQ-028 rst SHALL force state=IDLE, busy=0, hi=0, lo=0, counter=0 at the next edge, including mid-operation; rst overrides all other inputs.

Structure
REQ-029 The mult_mc/multu_mc/div_mc/divu_mc encodings SHALL live in the shared define.v header; FSM state encodings stay local to the module.
REQ-030 The iteration datapath (partial remainder, quotient shift, trial subtract) SHALL be one sub-module, div_iter, combinational per step, with its state registered in muldiv_unit.

Verification
REQ-031 mult 0xFFFFFFFF x 0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE after E2; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE; busy high for 2 cycles.
REQ-032 div 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after exactly 33 busy cycles; divu with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
REQ-033 div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; then divu 5 / 0 with HI=LO=0x0000ABCD preloaded -> HI/LO still 0x0000ABCD.
REQ-034 Start div, assert cancel at E10 -> IDLE next cycle, HI/LO unchanged; then hi_we with wdata=0x00001234 -> HI=0x00001234, LO unchanged.
REQ-035 During a busy div, pulse mul_valid (multu 3x3) and lo_we (0xDEAD) -> both ignored and the div result is correct; rst at E20 of a new div -> hi=lo=0, busy=0 at the next edge.
